// File: rtl/load_store_unit.sv
// load_store_unit: MIPS byte/half/word loads and stores onto a word-wide data memory
module load_store_unit #(
  parameter int DM_DEPTH   = 1024,
  parameter bit BIG_ENDIAN = 1'b1
) (
  input  logic        clk,
  input  logic        rst_n,
  input  logic        req_valid,
  output logic        req_ready,
  input  logic [3:0]  req_op,
  input  logic [31:0] req_addr,
  input  logic [31:0] req_wdata,
  output logic        resp_valid,
  output logic [31:0] resp_rdata,
  output logic        resp_err,
  output logic [31:0] dm_address,
  output logic [31:0] dm_data_write,
  output logic        dm_mem_write,
  input  logic [31:0] dm_data_read
);
  localparam logic [2:0] IDLE = 3'd0, LD = 3'd1, RD = 3'd2, WR = 3'd3, ERR = 3'd4;
  localparam logic [29:0] DEPTH_W = 30'(DM_DEPTH);
  logic [2:0] state_q, state_d;
  logic [2:0] op_q;
  logic [31:0] addr_q, dwr_q, rdata_q;
  logic [15:0] wdata_q;
  logic valid_q, err_q, accept, bad;
  logic [1:0] bl;
  logic [4:0] sh;
  logic [31:0] shifted, mask, merged, ext;
  assign req_ready = state_q == IDLE;
  assign accept = req_valid && req_ready;
  assign bad = &req_op[1:0] || (req_op[1:0] == 2'b01 && req_addr[0]) ||
               (req_op[1:0] == 2'b10 && |req_addr[1:0]) || req_addr[31:2] >= DEPTH_W;
  // physical byte lane of the addressed offset; the half lane is its upper bit
  assign bl = BIG_ENDIAN ? ~addr_q[1:0] : addr_q[1:0];
  assign sh = op_q[0] ? {bl[1], 4'b0000} : {bl, 3'b000};
  assign shifted = dm_data_read >> sh;
  assign mask = (op_q[0] ? 32'h0000_FFFF : 32'h0000_00FF) << sh;
  assign merged = (dm_data_read & ~mask) | (({16'b0, wdata_q} << sh) & mask);
  assign dm_address = {2'b00, addr_q[31:2]};
  assign dm_mem_write = state_q == WR;
  assign dm_data_write = dwr_q;
  assign resp_valid = valid_q;
  assign resp_rdata = rdata_q;
  assign resp_err = err_q;
  // extract the addressed lane and sign/zero extend it; words pass through
  always_comb
    ext = op_q[1] ? dm_data_read :
          op_q[0] ? {{16{~op_q[2] & shifted[15]}}, shifted[15:0]} :
                    {{24{~op_q[2] & shifted[7]}}, shifted[7:0]};
  // sequencing: IDLE dispatches on accept, RD always feeds WR, every other state returns to IDLE
  always_comb
    state_d = state_q == IDLE ? (!accept ? IDLE : bad ? ERR : !req_op[3] ? LD : req_op[1] ? WR : RD) :
              state_q == RD ? WR : IDLE;
  // state, request latch, write word (SW data or merged sub-word) and response registers
  always_ff @(posedge clk or negedge rst_n)
    if (!rst_n) begin
      state_q <= IDLE;
      op_q    <= '0;
      addr_q  <= '0;
      wdata_q <= '0;
      dwr_q   <= '0;
      rdata_q <= '0;
      valid_q <= 1'b0;
      err_q   <= 1'b0;
    end else begin
      state_q <= state_d;
      valid_q <= state_q inside {LD, WR, ERR};
      err_q   <= state_q == ERR;
      rdata_q <= state_q == LD ? ext : '0;
      if (accept) begin
        op_q    <= req_op[2:0];
        addr_q  <= req_addr;
        wdata_q <= req_wdata[15:0];
      end
      if (state_q == RD) dwr_q <= merged;
      else if (accept && state_d == WR) dwr_q <= req_wdata;
    end
endmodule
